// File: rtl/psum_accum_relu.sv
// Per-pixel partial-sum accumulator with bias seeding, rounding shift, optional ReLU and
// signed saturation. One result per output pixel leaves over a valid/ready handshake.
module psum_accum_relu #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] cfg_cin_num,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu_en,
    input  logic [31:0]      bias,
    input  logic             psum_vld,
    input  logic [31:0]      psum_in,
    output logic             psum_rdy,
    output logic             out_vld,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_rdy,
    output logic             busy
);

    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_vld;
    logic [OUT_W-1:0]        r_out_data;

    logic                    w_stall;
    logic                    w_accept;
    logic [CNT_W-1:0]        w_n;
    logic                    w_last;
    logic                    w_final;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_half;
    logic signed [ACC_W-1:0] w_rsum;
    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_relu;
    logic [OUT_W-1:0]        w_post;

    // Handshake, group bookkeeping and the running sum including the incoming psum
    always_comb begin
        w_stall  = r_out_vld & ~out_rdy;
        w_accept = psum_vld & ~w_stall;
        // A programmed count of zero behaves like one psum per pixel
        w_n      = (cfg_cin_num == '0) ? CNT_W'(1) : cfg_cin_num;
        w_last   = (r_cnt == (w_n - CNT_W'(1)));
        w_final  = w_accept & w_last;
        w_base   = (r_cnt == '0) ? {{(ACC_W-32){bias[31]}}, bias} : r_acc;
        w_sum    = w_base + {{(ACC_W-32){psum_in[31]}}, psum_in};
    end

    // Post-processing of the final sum: round-half-up shift, ReLU, saturate
    always_comb begin
        w_half = '0;
        if (cfg_shift != 5'd0) begin
            w_half = {{(ACC_W-1){1'b0}}, 1'b1} << (cfg_shift - 5'd1);
        end
        // With no shift w_half is zero and the shift is a pass-through
        w_rsum = w_sum + w_half;
        w_rnd  = w_rsum >>> cfg_shift;
        w_relu = w_rnd;
        if (cfg_relu_en && w_rnd[ACC_W-1]) begin
            w_relu = '0;
        end
        if (w_relu > SatMax) begin
            w_post = SatMax[OUT_W-1:0];
        end else if (w_relu < SatMin) begin
            w_post = SatMin[OUT_W-1:0];
        end else begin
            w_post = w_relu[OUT_W-1:0];
        end
    end

    // Channel counter and accumulator; both freeze while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
        end
    end

    // Output register; a final accept in the same cycle as a handshake keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else if (clr) begin
            r_out_vld <= 1'b0;
        end else if (w_final) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_post;
        end else if (r_out_vld && out_rdy) begin
            r_out_vld <= 1'b0;
        end
    end

    assign psum_rdy = ~w_stall;
    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign busy     = (r_cnt != '0) | r_out_vld;

endmodule

// File: tb/tb_psum_accum_relu.sv
// Randomized scoreboard bench for psum_accum_relu: the driver pushes group-level expected
// results, a separate monitor pops them on every output handshake.
module tb_psum_accum_relu;

    localparam int ACC_W = 40;
    localparam int OUT_W = 16;
    localparam int CNT_W = 10;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic [CNT_W-1:0] cfg_cin_num;
    logic [4:0]       cfg_shift;
    logic             cfg_relu_en;
    logic [31:0]      bias;
    logic             psum_vld;
    logic [31:0]      psum_in;
    logic             psum_rdy;
    logic             out_vld;
    logic [OUT_W-1:0] out_data;
    logic             out_rdy;
    logic             busy;

    int     n_checks;
    int     n_errors;
    longint exp_q[$];
    bit     rdy_mode;   // 1: random out_rdy, 0: out_rdy follows rdy_force
    bit     rdy_force;

    psum_accum_relu #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .cfg_cin_num (cfg_cin_num),
        .cfg_shift   (cfg_shift),
        .cfg_relu_en (cfg_relu_en),
        .bias        (bias),
        .psum_vld    (psum_vld),
        .psum_in     (psum_in),
        .psum_rdy    (psum_rdy),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .out_rdy     (out_rdy),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sign-extend the low 40 bits: accumulator arithmetic wraps modulo 2^40
    function automatic longint wrap40(input longint v);
        longint t;
        t = v <<< 24;
        return t >>> 24;
    endfunction

    // Reference: rounding shift, optional ReLU, saturation to 16-bit signed
    function automatic longint post_model(input longint x, input int s, input bit relu);
        longint r;
        r = wrap40(x);
        if (s > 0) begin
            r = wrap40(r + (longint'(1) <<< (s - 1)));
            r = r >>> s;
        end
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic longint sx32(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    // out_rdy driver, changed just after the rising edge
    initial begin
        out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_rdy = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: pops on each handshake and checks data stays stable while stalled
    initial begin
        bit             held;
        logic [OUT_W-1:0] held_data;
        longint         e;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held && out_vld) begin
                    check("hold_stable", longint'($signed(out_data)),
                          longint'($signed(held_data)));
                end
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", longint'($signed(out_data)), -99999);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", longint'($signed(out_data)), e);
                    end
                end
                held = out_vld && !out_rdy;
                held_data = out_data;
            end
        end
    end

    // Offer one psum and hold it until accepted (bounded)
    task automatic send_psum(input logic [31:0] v);
        bit done;
        done = 1'b0;
        psum_vld = 1'b1;
        psum_in  = v;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            done = psum_rdy;
            @(posedge clk);
            #1;
        end
        if (!done) check("psum_accept_timeout", 0, 1);
        psum_vld = 1'b0;
        psum_in  = $urandom;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            ok = !busy && (exp_q.size() == 0);
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int n, input int s, input bit relu, input int b);
        cfg_cin_num = CNT_W'(n);
        cfg_shift   = 5'(s);
        cfg_relu_en = relu;
        bias        = 32'(b);
    endtask

    // Issue one whole group with expected result computed from the group sum
    task automatic run_group(input int n, input int s, input bit relu, input int b);
        logic [31:0] p[$];
        longint      sum;
        int          ne;
        ne  = (n == 0) ? 1 : n;
        sum = longint'(b);
        for (int i = 0; i < ne; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: v = 32'($urandom_range(0, 200000)) - 32'd100000;
            endcase
            p.push_back(v);
            sum += sx32(v);
        end
        exp_q.push_back(post_model(sum, s, relu));
        foreach (p[i]) send_psum(p[i]);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        rst_n = 1'b0;
        clr = 1'b0;
        psum_vld = 1'b0;
        psum_in = '0;
        set_cfg(1, 0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_vld", longint'(out_vld), 0);
        check("rst_out_data", longint'(out_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_psum_rdy", longint'(psum_rdy), 1);
        check("rst_busy", longint'(busy), 0);

        // Three-channel group with bias; latency one cycle after the final accept
        set_cfg(3, 0, 1'b0, 10);
        @(posedge clk);
        #1;
        exp_q.push_back(95);
        send_psum(32'd100);
        send_psum(-32'sd20);
        check("t1_vld_before_final", longint'(out_vld), 0);
        send_psum(32'd5);
        check("t1_vld_after_final", longint'(out_vld), 1);
        wait_idle();

        // ReLU on and off
        set_cfg(1, 0, 1'b1, 0);
        exp_q.push_back(0);
        send_psum(-32'sd7);
        wait_idle();
        set_cfg(1, 0, 1'b0, 0);
        exp_q.push_back(-7);
        send_psum(-32'sd7);
        wait_idle();

        // Saturation at both ends without accumulator wrap
        set_cfg(2, 0, 1'b0, 0);
        exp_q.push_back(32767);
        send_psum(32'h7FFF_FFFF);
        send_psum(32'h7FFF_FFFF);
        exp_q.push_back(-32768);
        send_psum(32'h8000_0000);
        send_psum(32'h8000_0000);
        wait_idle();

        // Rounding shift
        set_cfg(1, 2, 1'b0, 0);
        exp_q.push_back(3);
        send_psum(32'd13);
        exp_q.push_back(-3);
        send_psum(-32'sd13);
        exp_q.push_back(4);
        send_psum(32'd14);
        wait_idle();

        // Back-pressure: first result held, second psum stalled, then replaced in one cycle
        set_cfg(1, 0, 1'b0, 0);
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(1234);
        exp_q.push_back(-4321);
        send_psum(32'd1234);
        fork
            send_psum(-32'sd4321);
            begin
                @(negedge clk);
                check("t5_stall_psum_rdy", longint'(psum_rdy), 0);
                check("t5_hold_vld", longint'(out_vld), 1);
                @(negedge clk);
                check("t5_hold_data", longint'($signed(out_data)), 1234);
                rdy_force = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rdy_force = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("t5_vld_kept", longint'(out_vld), 1);
                check("t5_new_data", longint'($signed(out_data)), -4321);
            end
        join
        rdy_force = 1'b1;
        wait_idle();

        // Soft clear mid-group, then a full group of four
        set_cfg(4, 0, 1'b0, 3);
        send_psum(32'd1000);
        send_psum(32'd2000);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("t6_clr_busy", longint'(busy), 0);
        exp_q.push_back(3 + 1 + 2 + 3 + 4);
        send_psum(32'd1);
        send_psum(32'd2);
        send_psum(32'd3);
        send_psum(32'd4);
        wait_idle();

        // Asynchronous reset while holding a result
        set_cfg(1, 0, 1'b0, 0);
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_psum(32'd50);
        check("t6_hold_before_rst", longint'(out_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", longint'(out_vld), 0);
        check("t6_rst_data", longint'(out_data), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_psum_rdy", longint'(psum_rdy), 1);
        check("t6_rst_busy", longint'(busy), 0);
        rdy_force = 1'b1;

        // Random groups with random out_rdy; cfg changes only between idle batches
        for (int batch = 0; batch < 10; batch++) begin
            int  n;
            int  s;
            bit  relu;
            rdy_mode = 1'b0;
            wait_idle();
            n    = $urandom_range(0, 4);
            s    = $urandom_range(0, 24);
            relu = 1'($urandom_range(0, 1));
            set_cfg(n, s, relu, 0);
            rdy_mode = 1'b1;
            for (int g = 0; g < 20; g++) begin
                int b;
                b = int'($urandom);
                bias = 32'(b);
                run_group(n, s, relu, b);
            end
        end
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        wait_idle();
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
